count_ctrl: RTL and testbench

Command-driven controller for the loadable mod-(MAX+1) up/down counter. It sits on the counter's control side: it drives `load`, `din` and `up_down` and reads back `count`. It accepts LOAD / RUN-UP / RUN-DOWN / CHECK commands over a valid/ready handshake and holds the counter value between commands. It reports one response per command, with a mismatch flag against an internally tracked expected value.

---
 rtl/count_ctrl_if.sv | 33 +++
 rtl/count_ctrl.sv | 118 +++++++++++
 tb/tb_count_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// Command, response and counter-side signals of count_ctrl.
// master = command source / counter side, slave = count_ctrl.
interface count_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int LENW  = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [LENW-1:0]  cmd_len;
   logic [WIDTH-1:0] count_in;
   logic             load;
   logic [WIDTH-1:0] din;
   logic             up_down;
   logic             busy;
   logic             rsp_valid;
   logic             rsp_err;
   logic [WIDTH-1:0] rsp_count;
   logic [15:0]      err_count;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_len, count_in,
      input  cmd_ready, load, din, up_down, busy,
             rsp_valid, rsp_err, rsp_count, err_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_len, count_in,
      output cmd_ready, load, din, up_down, busy,
             rsp_valid, rsp_err, rsp_count, err_count
   );
endinterface

// File: rtl/count_ctrl.sv
// Drives a mod-(MAX+1) up/down counter from LOAD/UP/DOWN/CHECK commands; one response per command.
// Response 1 cycle after accept (CHECK, len 0), 2 (LOAD), len+1 (run); one command in flight, no response backpressure.
module count_ctrl #(
   parameter int WIDTH = 4,
   parameter int MAX   = 11,
   parameter int LENW  = 8
) (
   input logic         clock,
   input logic         resetn,
   count_ctrl_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_CHECK} state_t;

   localparam logic [1:0]       OP_LOAD  = 2'b00;
   localparam logic [1:0]       OP_UP    = 2'b01;
   localparam logic [1:0]       OP_DOWN  = 2'b10;
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic [LENW-1:0]  ONE_L    = LENW'(1);

   state_t           state, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] expected;
   logic [LENW-1:0]  remaining;
   logic             rsp_valid_q;
   logic [15:0]      err_count_q;
   logic             mismatch;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
      if (up)
         step = (v == MAX_V) ? '0 : v + ONE_W;
      else
         step = (v == '0) ? MAX_V : v - ONE_W;
   endfunction

   assign mismatch = (bus.count_in != expected);

   // Any cycle that is not a run step reloads the counter with its own value.
   always_comb begin
      state_d       = state;
      bus.cmd_ready = 1'b0;
      bus.load      = 1'b1;
      bus.din       = bus.count_in;
      bus.up_down   = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_LOAD:        state_d = ST_LOAD;
                  OP_UP, OP_DOWN: state_d = (bus.cmd_len == '0) ? ST_CHECK : ST_RUN;
                  default:        state_d = ST_CHECK;
               endcase
            end
         end
         ST_LOAD: begin
            bus.din = data_q;
            state_d = ST_CHECK;
         end
         ST_RUN: begin
            bus.load    = 1'b0;
            bus.up_down = (op_q == OP_UP);
            if (remaining == ONE_L)
               state_d = ST_CHECK;
         end
         ST_CHECK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state != ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_valid_q & mismatch;
   assign bus.rsp_count = rsp_valid_q ? bus.count_in : '0;
   assign bus.err_count = err_count_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         op_q        <= '0;
         data_q      <= '0;
         expected    <= '0;
         remaining   <= '0;
         rsp_valid_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state       <= state_d;
         // The response strobe is timed to coincide with the CHECK state itself.
         rsp_valid_q <= (state_d == ST_CHECK);
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q      <= bus.cmd_op;
                  data_q    <= bus.cmd_data;
                  remaining <= bus.cmd_len;
                  if (bus.cmd_op == OP_UP || bus.cmd_op == OP_DOWN)
                     expected <= bus.count_in;
                  else if (bus.cmd_op != OP_LOAD)
                     expected <= bus.cmd_data;
               end
            end
            ST_LOAD: expected <= data_q;
            ST_RUN: begin
               expected  <= step(expected, op_q == OP_UP);
               remaining <= remaining - ONE_L;
            end
            ST_CHECK: begin
               if (mismatch && err_count_q != 16'hFFFF)
                  err_count_q <= err_count_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: a behavioural counter on the control side plus a cycle-indexed model
// of the command timeline, checked every cycle, with directed literal checks on top.
module tb_count_ctrl;

   localparam int WIDTH = 4;
   localparam int MAX   = 11;
   localparam int LENW  = 8;
   localparam int M     = MAX + 1;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_CHECK = 2'b11;

   logic clock  = 1'b0;
   logic resetn = 1'b1;

   count_ctrl_if #(.WIDTH(WIDTH), .LENW(LENW)) bus();

   count_ctrl #(.WIDTH(WIDTH), .MAX(MAX), .LENW(LENW)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // The counter being controlled, following its contract.
   logic [WIDTH-1:0] cnt = '0;
   assign bus.count_in = cnt;
   always @(posedge clock) begin
      if (bus.load)
         cnt <= bus.din;
      else if (bus.up_down)
         cnt <= (int'(cnt) == MAX) ? '0 : WIDTH'(int'(cnt) + 1);
      else
         cnt <= (cnt == '0) ? WIDTH'(MAX) : WIDTH'(int'(cnt) - 1);
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: the last accepted command, its accept cycle and the count it started from.
   int         cyc    = 0;
   bit         a_act  = 1'b0;
   int         a_T    = 0;
   int         a_dur  = 0;
   int         a_N    = 0;
   int         a_base = 0;
   int         a_data = 0;
   logic [1:0] a_op   = 2'b00;
   int         m_err  = 0;
   int         ud_cycles = 0;

   function automatic int dur_of(input logic [1:0] op, input int len);
      if (op == OP_LOAD)  return 2;
      if (op == OP_CHECK) return 1;
      return (len == 0) ? 1 : len + 1;
   endfunction

   function automatic int cnt_at(input int t);
      int k;
      if (!a_act || t <= a_T) return a_base;
      k = t - a_T - 1;
      if (k > a_N) k = a_N;
      case (a_op)
         OP_LOAD: return (t >= a_T + 2) ? a_data : a_base;
         OP_UP:   return (a_base + k) % M;
         OP_DOWN: return (a_base - (k % M) + M) % M;
         default: return a_base;
      endcase
   endfunction

   function automatic bit busy_at(input int t);
      return a_act && t > a_T && t <= a_T + a_dur;
   endfunction

   function automatic bit rsp_at(input int t);
      return a_act && t == a_T + a_dur;
   endfunction

   function automatic bit run_at(input int t);
      return a_act && (a_op == OP_UP || a_op == OP_DOWN) && t > a_T && t <= a_T + a_N;
   endfunction

   function automatic bit err_exp();
      return (a_op == OP_CHECK) && (a_base != a_data);
   endfunction

   always @(posedge clock) begin
      if (!resetn) begin
         a_base = cnt_at(cyc);
         a_act  = 1'b0;
         m_err  = 0;
      end else begin
         if (rsp_at(cyc) && err_exp() && m_err < 65535)
            m_err++;
         if (bus.cmd_valid && !busy_at(cyc)) begin
            a_base = cnt_at(cyc);
            a_act  = 1'b1;
            a_T    = cyc;
            a_op   = bus.cmd_op;
            a_data = int'(bus.cmd_data);
            a_N    = int'(bus.cmd_len);
            a_dur  = dur_of(bus.cmd_op, int'(bus.cmd_len));
         end
      end
      cyc++;
   end

   always @(negedge clock) begin : compare
      bit bsy, rv, runv;
      int exp_din;
      bsy  = resetn && busy_at(cyc);
      rv   = resetn && rsp_at(cyc);
      runv = resetn && run_at(cyc);
      chk("cmd_ready", bus.cmd_ready, !bsy);
      chk("busy", bus.busy, bsy);
      chk("rsp_valid", bus.rsp_valid, rv);
      if (rv) begin
         chk("rsp_count", bus.rsp_count, cnt_at(cyc));
         chk("rsp_err", bus.rsp_err, err_exp());
      end
      chk("load", bus.load, !runv);
      chk("up_down", bus.up_down, runv && a_op == OP_UP);
      if (!runv) begin
         exp_din = (resetn && a_act && a_op == OP_LOAD && cyc == a_T + 1) ? a_data : cnt_at(cyc);
         chk("din", bus.din, exp_din);
      end
      chk("count", cnt, cnt_at(cyc));
      chk("err_count", bus.err_count, resetn ? m_err : 0);
      if (bus.up_down) ud_cycles++;
   end

   task automatic send(input logic [1:0] op, input int data, input int len);
      int w;
      w = 0;
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = WIDTH'(data);
      bus.cmd_len   = LENW'(len);
      while (!bus.cmd_ready && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (w >= 300) begin
         $display("FAIL accept_timeout: got %0d waits expected fewer than 300", w);
         bad++;
         total++;
      end
      @(posedge clock);
   endtask

   task automatic wait_rsp(input string nm, input int exp_cnt, input int exp_err, input int lat);
      int w;
      w = 0;
      do begin
         @(negedge clock);
         bus.cmd_valid = 1'b0;
         w++;
      end while (!bus.rsp_valid && w < 300);
      chk({nm, "_lat"}, w, lat);
      chk({nm, "_cnt"}, bus.rsp_count, exp_cnt);
      chk({nm, "_err"}, bus.rsp_err, exp_err);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = '0;
      bus.cmd_len   = '0;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp", bus.rsp_valid, 0);
      chk("rst_errc", bus.err_count, 0);
      resetn = 1'b1;

      send(OP_LOAD, 5, 0);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      chk("ld5_load", bus.load, 1);
      chk("ld5_din", bus.din, 5);
      wait_rsp("ld5", 5, 0, 1);

      send(OP_LOAD, 9, 0);
      wait_rsp("ld9", 9, 0, 2);
      ud_cycles = 0;
      send(OP_UP, 0, 4);
      wait_rsp("up4", 1, 0, 5);
      chk("up4_ud_cycles", ud_cycles, 4);

      send(OP_LOAD, 2, 0);
      wait_rsp("ld2", 2, 0, 2);
      send(OP_DOWN, 0, 3);
      wait_rsp("dn3", 11, 0, 4);

      send(OP_LOAD, 7, 0);
      wait_rsp("ld7", 7, 0, 2);
      repeat (10) @(negedge clock);
      send(OP_CHECK, 7, 0);
      wait_rsp("chk7", 7, 0, 1);
      send(OP_CHECK, 6, 0);
      wait_rsp("chk6", 7, 1, 1);
      @(negedge clock);
      chk("chk6_errc", bus.err_count, 1);
      chk("chk6_hold", cnt, 7);

      send(OP_LOAD, 0, 0);
      wait_rsp("ld0", 0, 0, 2);
      send(OP_DOWN, 0, 1);
      wait_rsp("dn1", 11, 0, 2);
      send(OP_UP, 0, 1);
      wait_rsp("up1", 0, 0, 2);
      send(OP_DOWN, 0, 25);
      wait_rsp("dn25", 11, 0, 26);

      // Out-of-range load value is passed through unchanged.
      send(OP_LOAD, 14, 0);
      wait_rsp("ld14", 14, 0, 2);
      send(OP_CHECK, 3, 0);
      wait_rsp("chk3", 14, 1, 1);
      @(negedge clock);
      chk("chk3_errc", bus.err_count, 2);
      send(OP_LOAD, 4, 0);
      wait_rsp("ld4", 4, 0, 2);

      // Reset in the third RUN cycle of UP 8 from 4.
      send(OP_UP, 0, 8);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 resetn = 1'b0;
      #1;
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_ready", bus.cmd_ready, 1);
      chk("mrst_load", bus.load, 1);
      chk("mrst_ud", bus.up_down, 0);
      chk("mrst_rsp", bus.rsp_valid, 0);
      chk("mrst_errc", bus.err_count, 0);
      chk("mrst_count", cnt, 6);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      chk("post_ready", bus.cmd_ready, 1);
      chk("post_count", cnt, 6);
      chk("post_errc", bus.err_count, 0);

      // Back-to-back UP len 0 with cmd_valid held high.
      send(OP_UP, 0, 0);
      @(negedge clock);
      chk("b2b_rsp", bus.rsp_valid, 1);
      chk("b2b_cnt", bus.rsp_count, 6);
      chk("b2b_ready", bus.cmd_ready, 0);
      chk("b2b_busy", bus.busy, 1);
      @(negedge clock);
      chk("b2b_ready2", bus.cmd_ready, 1);
      @(posedge clock);
      wait_rsp("b2b2", 6, 0, 1);
      send(OP_CHECK, 6, 0);
      wait_rsp("final", 6, 0, 1);

      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
